// File: rtl/key_filter_multi.sv
// Multi-channel push-button debouncer. Each channel synchronises an
// active-low key, filters bounce on press and release, and emits a
// debounced level, a press/release flag, a long-press pulse and an
// optional auto-repeat pulse.

module key_filter_ch #(
  parameter int FILTER_CYCLES = 8,
  parameter int LONG_CYCLES   = 40,
  parameter int REPEAT_CYCLES = 10,
  parameter int REPEAT_EN     = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic flag_o,
  output logic state_o,
  output logic long_o,
  output logic repeat_o
);
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int FW   = $clog2(FILTER_CYCLES);
  localparam int HW   = $clog2(HMAX);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [HW-1:0] L_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_F0   = 4'b0010;
  localparam logic [3:0] S_DOWN = 4'b0100;
  localparam logic [3:0] S_F1   = 4'b1000;

  logic          s1_q, s2_q, s3_q;
  logic          nedge, pedge;
  logic [3:0]    st_q, st_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          ld_q, ld_d;
  logic          flag_q, flag_d, kst_q, kst_d, long_q, long_d, rep_q, rep_d;

  assign nedge = s3_q & ~s2_q;
  assign pedge = ~s3_q & s2_q;

  // Two-flop synchroniser plus a delay flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= key_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Filter/hold FSM: hold counter only runs in DOWN, so a release
  // bounce freezes long/repeat timing instead of restarting it.
  always_comb begin
    st_d   = st_q;
    fcnt_d = fcnt_q;
    hcnt_d = hcnt_q;
    ld_d   = ld_q;
    kst_d  = kst_q;
    flag_d = 1'b0;
    long_d = 1'b0;
    rep_d  = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (nedge) begin
          st_d   = S_F0;
          fcnt_d = '0;
        end
      end
      S_F0: begin
        if (pedge) begin
          st_d   = S_IDLE;
          fcnt_d = '0;
        end else if (fcnt_q == F_LAST) begin
          fcnt_d = '0;
          if (!s2_q) begin
            st_d   = S_DOWN;
            flag_d = 1'b1;
            kst_d  = 1'b0;
            hcnt_d = '0;
            ld_d   = 1'b0;
          end else begin
            st_d = S_IDLE;
          end
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      S_DOWN: begin
        if (!ld_q) begin
          if (hcnt_q == L_LAST) begin
            long_d = 1'b1;
            ld_d   = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else if (REPEAT_EN != 0) begin
          if (hcnt_q == R_LAST) begin
            rep_d  = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        // with repeat disabled the counter simply parks after key_long
        if (pedge) begin
          st_d   = S_F1;
          fcnt_d = '0;
        end
      end
      S_F1: begin
        if (nedge) begin
          st_d   = S_DOWN;
          fcnt_d = '0;
        end else if (fcnt_q == F_LAST) begin
          fcnt_d = '0;
          if (s2_q) begin
            st_d   = S_IDLE;
            flag_d = 1'b1;
            kst_d  = 1'b1;
          end else begin
            st_d = S_DOWN;
          end
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: begin
        st_d   = S_IDLE;
        fcnt_d = '0;
        hcnt_d = '0;
      end
    endcase
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= S_IDLE;
      fcnt_q <= '0;
      hcnt_q <= '0;
      ld_q   <= 1'b0;
      kst_q  <= 1'b1;
      flag_q <= 1'b0;
      long_q <= 1'b0;
      rep_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      fcnt_q <= fcnt_d;
      hcnt_q <= hcnt_d;
      ld_q   <= ld_d;
      kst_q  <= kst_d;
      flag_q <= flag_d;
      long_q <= long_d;
      rep_q  <= rep_d;
    end
  end

  assign flag_o   = flag_q;
  assign state_o  = kst_q;
  assign long_o   = long_q;
  assign repeat_o = rep_q;
endmodule

module key_filter_multi #(
  parameter int N_KEYS        = 4,
  parameter int FILTER_CYCLES = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_KEYS-1:0] key_in_i,
  output logic [N_KEYS-1:0] key_flag_o,
  output logic [N_KEYS-1:0] key_state_o,
  output logic [N_KEYS-1:0] key_long_o,
  output logic [N_KEYS-1:0] key_repeat_o
);
  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_filter_ch #(
      .FILTER_CYCLES(FILTER_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (REPEAT_EN)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .key_i   (key_in_i[g]),
      .flag_o  (key_flag_o[g]),
      .state_o (key_state_o[g]),
      .long_o  (key_long_o[g]),
      .repeat_o(key_repeat_o[g])
    );
  end
endmodule
